// File: rtl/tristate_bus_port.sv
// Registered bidirectional bus port: sequences write drive, turnaround gap and
// read sampling on one shared tristate bus behind a ready/valid requester side.
module tristate_bus_port #(
  parameter int WIDTH        = 8,
  parameter int DRIVE_CYCLES = 1,
  parameter int TURNAROUND   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             bus_oe,
  inout  wire  [WIDTH-1:0] bus
);

  localparam int MAXC = (DRIVE_CYCLES > TURNAROUND) ? DRIVE_CYCLES : TURNAROUND;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

  localparam logic [CW-1:0] CNT_DRIVE = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_TURN  = (TURNAROUND > 0) ? CW'(TURNAROUND - 1) : '0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_TURN   = 2'd2;
  localparam logic [1:0] S_SAMPLE = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] drv;

  assign ready = (state == S_IDLE);
  assign bus   = bus_oe ? drv : {WIDTH{1'bz}};

  // Write wins over read in IDLE; the requester keeps rd_req asserted.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (wr_valid)    state_nxt = S_DRIVE;
        else if (rd_req) state_nxt = S_SAMPLE;
      end
      S_DRIVE:  if (cnt == '0) state_nxt = (TURNAROUND > 0) ? S_TURN : S_IDLE;
      S_TURN:   if (cnt == '0) state_nxt = S_IDLE;
      S_SAMPLE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // bus_oe is its own flop, cleared asynchronously so reset releases the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      drv      <= '0;
      bus_oe   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      bus_oe   <= (state_nxt == S_DRIVE);
      rd_valid <= (state == S_SAMPLE);
      if (state == S_SAMPLE) rd_data <= bus;
      case (state)
        S_IDLE: if (wr_valid) begin
          drv <= wr_data;
          cnt <= CNT_DRIVE;
        end
        S_DRIVE, S_TURN: begin
          if (cnt != '0)           cnt <= cnt - 1'b1;
          else if (state == S_DRIVE) cnt <= CNT_TURN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_port.sv
// Directed bench for tristate_bus_port across four parameter sets sharing clk/rst_n.
module tb_tristate_bus_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // a: defaults (8,1,1) with external agent
  logic       rdy_a, wv_a, rq_a, rv_a, oe_a, ag_en_a;
  logic [7:0] wd_a, rdd_a, ag_a;
  wire  [7:0] bus_a;
  assign bus_a = ag_en_a ? ag_a : 8'hzz;
  tristate_bus_port #(.WIDTH(8), .DRIVE_CYCLES(1), .TURNAROUND(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ready(rdy_a), .wr_valid(wv_a), .wr_data(wd_a),
    .rd_req(rq_a), .rd_valid(rv_a), .rd_data(rdd_a), .bus_oe(oe_a), .bus(bus_a));

  // b: (16,3,2) with external agent
  logic        rdy_b, wv_b, rq_b, rv_b, oe_b, ag_en_b;
  logic [15:0] wd_b, rdd_b, ag_b;
  wire  [15:0] bus_b;
  assign bus_b = ag_en_b ? ag_b : 16'hzzzz;
  tristate_bus_port #(.WIDTH(16), .DRIVE_CYCLES(3), .TURNAROUND(2)) u_b (
    .clk(clk), .rst_n(rst_n), .ready(rdy_b), .wr_valid(wv_b), .wr_data(wd_b),
    .rd_req(rq_b), .rd_valid(rv_b), .rd_data(rdd_b), .bus_oe(oe_b), .bus(bus_b));

  // c: (8,4,1) for reset mid-write
  logic       rdy_c, wv_c, rq_c, rv_c, oe_c;
  logic [7:0] wd_c, rdd_c;
  wire  [7:0] bus_c;
  tristate_bus_port #(.WIDTH(8), .DRIVE_CYCLES(4), .TURNAROUND(1)) u_c (
    .clk(clk), .rst_n(rst_n), .ready(rdy_c), .wr_valid(wv_c), .wr_data(wd_c),
    .rd_req(rq_c), .rd_valid(rv_c), .rd_data(rdd_c), .bus_oe(oe_c), .bus(bus_c));

  // d: (8,1,0) no turnaround
  logic       rdy_d, wv_d, rq_d, rv_d, oe_d;
  logic [7:0] wd_d, rdd_d;
  wire  [7:0] bus_d;
  tristate_bus_port #(.WIDTH(8), .DRIVE_CYCLES(1), .TURNAROUND(0)) u_d (
    .clk(clk), .rst_n(rst_n), .ready(rdy_d), .wr_valid(wv_d), .wr_data(wd_d),
    .rd_req(rq_d), .rd_valid(rv_d), .rd_data(rdd_d), .bus_oe(oe_d), .bus(bus_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    wv_a = 1'b1; wd_a = 8'hEE; rq_a = 1'b0; ag_a = 8'h00; ag_en_a = 1'b0;
    wv_b = 1'b0; wd_b = 16'h0;  rq_b = 1'b0; ag_b = 16'h0; ag_en_b = 1'b0;
    wv_c = 1'b0; wd_c = 8'h0;   rq_c = 1'b0;
    wv_d = 1'b0; wd_d = 8'h0;   rq_d = 1'b0;

    // reset held with a write pending
    @(negedge clk);
    chk("rst_oe",     oe_a,  1'b0);
    chk("rst_ready",  rdy_a, 1'b1);
    chk("rst_rvalid", rv_a,  1'b0);
    chk("rst_rdata",  rdd_a, 8'h00);
    wv_a = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_oe", oe_a, 1'b0);

    // default write A5
    wv_a = 1'b1; wd_a = 8'hA5;
    @(negedge clk);
    wv_a = 1'b0;
    chk("wr_bus",   bus_a, 8'hA5);
    chk("wr_oe1",   oe_a,  1'b1);
    chk("wr_rdy1",  rdy_a, 1'b0);
    @(negedge clk);
    chk("wr_oe2",   oe_a,  1'b0);
    chk("wr_rdy2",  rdy_a, 1'b0);
    @(negedge clk);
    chk("wr_rdy3",  rdy_a, 1'b1);

    // read of agent-driven 3C, then write accepted while rd_valid is high
    ag_a = 8'h3C; ag_en_a = 1'b1; rq_a = 1'b1;
    @(negedge clk);
    rq_a = 1'b0;
    chk("rd_oe",    oe_a,  1'b0);
    chk("rd_rdy",   rdy_a, 1'b0);
    chk("rd_rv0",   rv_a,  1'b0);
    @(negedge clk);
    chk("rd_rv1",   rv_a,  1'b1);
    chk("rd_data",  rdd_a, 8'h3C);
    chk("rd_rdy2",  rdy_a, 1'b1);
    ag_en_a = 1'b0;
    wv_a = 1'b1; wd_a = 8'h5A;
    @(negedge clk);
    wv_a = 1'b0;
    chk("r2w_bus",  bus_a, 8'h5A);
    chk("r2w_oe",   oe_a,  1'b1);
    chk("rd_rv_off", rv_a, 1'b0);
    chk("rd_sticky", rdd_a, 8'h3C);
    @(negedge clk);
    @(negedge clk);

    // priority + turnaround on (16,3,2)
    wv_b = 1'b1; wd_b = 16'hBEEF; rq_b = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      wv_b = 1'b0;
      if (k <= 3) begin
        chk($sformatf("pri_bus%0d", k), bus_b, 16'hBEEF);
        chk($sformatf("pri_oe%0d", k),  oe_b,  1'b1);
        chk($sformatf("pri_rdy%0d", k), rdy_b, 1'b0);
      end else if (k <= 5) begin
        chk($sformatf("pri_oe%0d", k),  oe_b,  1'b0);
        chk($sformatf("pri_rdy%0d", k), rdy_b, 1'b0);
      end else begin
        chk("pri_rdy6", rdy_b, 1'b1);
        ag_b = 16'h1234; ag_en_b = 1'b1;
      end
    end
    @(negedge clk);
    rq_b = 1'b0;
    chk("pri_samp_oe",  oe_b,  1'b0);
    chk("pri_samp_rdy", rdy_b, 1'b0);
    @(negedge clk);
    chk("pri_rv",   rv_b,  1'b1);
    chk("pri_rd",   rdd_b, 16'h1234);
    ag_en_b = 1'b0;

    // reset during the 2nd DRIVE cycle of (8,4,1)
    wv_c = 1'b1; wd_c = 8'h77;
    @(negedge clk);
    wv_c = 1'b0;
    chk("mid_bus1", bus_c, 8'h77);
    chk("mid_oe1",  oe_c,  1'b1);
    @(posedge clk);
    #2;
    chk("mid_oe2",  oe_c,  1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_async_oe",  oe_c,  1'b0);
    chk("mid_async_rdy", rdy_c, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("mid_post_oe%0d", k),  oe_c,  1'b0);
      chk($sformatf("mid_post_rdy%0d", k), rdy_c, 1'b1);
    end

    // back-to-back writes with no turnaround
    wv_d = 1'b1; wd_d = 8'h01;
    @(negedge clk);
    wd_d = 8'h02;
    chk("t0_bus1", bus_d, 8'h01);
    chk("t0_oe1",  oe_d,  1'b1);
    chk("t0_gap1", oe_d | rdy_d, 1'b1);
    @(negedge clk);
    chk("t0_oe2",  oe_d,  1'b0);
    chk("t0_rdy2", rdy_d, 1'b1);
    @(negedge clk);
    wv_d = 1'b0;
    chk("t0_bus3", bus_d, 8'h02);
    chk("t0_oe3",  oe_d,  1'b1);
    chk("t0_gap3", oe_d | rdy_d, 1'b1);
    @(negedge clk);
    chk("t0_oe4",  oe_d,  1'b0);
    chk("t0_rdy4", rdy_d, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tristate_bus_port.md
# tristate_bus_port

Parametrised, clocked bidirectional bus port: the registered, multi-bit successor to the team's single-bit `bufif1` tristate driver. The block owns one shared `WIDTH`-bit tristate bus and sequences write cycles (drive), read cycles (release and sample) and a bus-turnaround gap between them, so that no two agents drive the bus in the same cycle. It sits between a local requester, using a valid/ready-style handshake, and an external shared bus segment.

## Interface
Parameters:
- `WIDTH`, 8: bus and data width in bits (≥1).
- `DRIVE_CYCLES`, 1: cycles the bus is actively driven per write (≥1).
- `TURNAROUND`, 1: idle, released cycles after a write before the next operation (≥0).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset is asynchronous and active-low.
- `ready`  out  1: high when the port accepts a new write or read this cycle.
- `wr_valid`  in  1: write request; accepted when `wr_valid && ready`.
- `wr_data`  in  WIDTH: write data, captured on acceptance.
- `rd_req`  in  1: read request; accepted when `rd_req && ready && !wr_valid`.
- `rd_valid`  out  1: one-cycle pulse; `rd_data` is valid.
- `rd_data`  out  WIDTH: sampled bus value; holds until the next read completes.
- `bus_oe`  out  1: registered output enable, for observation.
- `bus`  inout  WIDTH: shared bus; equals the drive register when `bus_oe`=1, else all-Z.

## Operation
- States: IDLE, DRIVE, TURN, SAMPLE.
- `ready` = (state == IDLE). `bus_oe` = 1 only in DRIVE.
- IDLE:
  - Write accepted: latch `wr_data` into the drive register, load the counter with `DRIVE_CYCLES-1`, and go to DRIVE.
  - Read accepted: go to SAMPLE.
  - Both `wr_valid` and `rd_req` high: the write wins and the read is not accepted. The requester holds `rd_req`.
- DRIVE:
  - Drive the bus and decrement the counter.
  - At count 0: go to TURN, loading `TURNAROUND-1`, if `TURNAROUND`>0. Otherwise go to IDLE.
- TURN:
  - Bus released. Decrement the counter.
  - At count 0: go to IDLE.
- SAMPLE:
  - Bus released. At the end of the cycle, register `bus` into `rd_data`, assert `rd_valid` for the next cycle, and go to IDLE.
- `rd_valid` is registered and lasts exactly one cycle. `rd_data` is sticky.
- Requests arriving outside IDLE are ignored. No queuing.
- The counter width is `$clog2(max(DRIVE_CYCLES,TURNAROUND)+1)`, minimum 1 bit. The counter saturates at 0 and never wraps.
- Asynchronous reset, including mid-operation:
  - State goes to IDLE and `bus_oe`=0, so the bus is Z immediately without waiting for a clock edge.
  - Reset values: `ready`=1, `rd_valid`=0, `rd_data`=0, drive register = 0.
  - An aborted write or read produces no further bus activity and no `rd_valid`.

## Timing
- Write accepted at edge E0:
  - `bus_oe`=1 during cycles E0+1 … E0+`DRIVE_CYCLES`.
  - Released for the next `TURNAROUND` cycles.
  - `ready`=1 again at cycle E0+`DRIVE_CYCLES`+`TURNAROUND`+1.
- Read accepted at E0:
  - SAMPLE in cycle E0+1, with the bus captured at edge E0+2.
  - `rd_valid`=1 and `ready`=1 in cycle E0+2.
  - Back-to-back reads are accepted every 2 cycles.
- A write followed by a read: the bus is never driven in the read's SAMPLE cycle, and at least `TURNAROUND` released cycles separate them.
- Read-to-write: no gap is required. A write can be accepted in the cycle `rd_valid` is high.
- `bus` changes only on `clk` rising edges, apart from asynchronous reset.

## Test plan
- Reset: hold `rst_n`=0 while `wr_valid`=1 → `bus`=Z, `bus_oe`=0, `ready`=1, `rd_valid`=0, `rd_data`=0.
- Write with defaults (W=8, D=1, T=1): `wr_data`=8'hA5 accepted at E0 → `bus`=8'hA5 in cycle E0+1, Z in E0+2, `ready`=1 in E0+3.
- Read: external agent drives 8'h3C, `rd_req` pulse at E0 → `bus_oe`=0 in E0+1, `rd_valid`=1 and `rd_data`=8'h3C in E0+2. After the agent releases, `rd_data` stays 8'h3C.
- Priority and turnaround (W=16, D=3, T=2): `wr_valid`=1 with `wr_data`=16'hBEEF and `rd_req`=1 at E0 → write wins and drives for 3 cycles, `ready` stays low for 5 cycles, and the held read is accepted at E0+6.
- Reset mid-write (D=4): assert `rst_n`=0 during the 2nd DRIVE cycle → `bus` goes Z asynchronously. After release: IDLE, no resumed drive.
- T=0: two back-to-back writes 8'h01 and 8'h02 → bus shows 01, Z, 02. No cycle has `bus_oe` low while `ready` is low.
